// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// A requester whose grant is revoked by the limit stays masked until it drops its request.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [3:0]       mask, mask_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       gnt_id_nxt;
  logic             gnt_valid_nxt;
  logic             timeout_nxt;

  logic [3:0]       elig;
  logic             win_found;
  logic [1:0]       winner;
  logic             owner_req;
  logic             hold_max;

  assign elig      = req & ~mask;
  assign owner_req = req[gnt_id];
  assign hold_max  = (hold_cnt == CNT_W'(MAX_HOLD));

  // First eligible requester at or after ptr, wrapping modulo 4.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    win_found = 1'b0;
    winner    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && elig[ptr + 2'(k)]) begin
        win_found = 1'b1;
        winner    = ptr + 2'(k);
      end
    end
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      mask      <= 4'b0000;
      gnt       <= 4'b0000;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_cnt_nxt;
      mask      <= mask_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = GRANT;
      GRANT:   if (!owner_req || hold_max) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the outputs and datapath registers.
  always_comb begin
    ptr_nxt       = ptr;
    hold_cnt_nxt  = hold_cnt;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    mask_nxt      = mask & req;
    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_nxt       = 4'b0001 << winner;
          gnt_id_nxt    = winner;
          gnt_valid_nxt = 1'b1;
          hold_cnt_nxt  = CNT_W'(1);
        end else begin
          gnt_nxt       = 4'b0000;
          gnt_valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (!owner_req || hold_max) begin
          gnt_nxt       = 4'b0000;
          gnt_valid_nxt = 1'b0;
          hold_cnt_nxt  = '0;
          ptr_nxt       = gnt_id + 2'd1;
          if (owner_req) begin
            // Forced revocation: the owner is locked out until it lets go.
            timeout_nxt      = 1'b1;
            mask_nxt[gnt_id] = 1'b1;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: a cycle model of the arbitration rules compared every
// cycle, invariant checks, and directed scenarios with hand-computed expectations.
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 when nobody holds the resource), cycles held, rotation start,
  // lockout set and the revocation pulse.
  int       m_owner;
  int       m_last_id;
  int       m_hold;
  int       m_ptr;
  bit [3:0] m_mask;
  bit       m_timeout;

  always @(posedge clk or negedge rst_n) begin
    bit [3:0] r;
    bit       found;
    int       c;
    if (!rst_n) begin
      m_owner = -1; m_last_id = 0; m_hold = 0; m_ptr = 0; m_mask = 4'b0; m_timeout = 0;
    end else begin
      r         = req;
      m_timeout = 0;
      if (m_owner < 0) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          c = (m_ptr + k) % 4;
          if (!found && r[c] && !m_mask[c]) begin
            found = 1; m_owner = c; m_last_id = c; m_hold = 1;
          end
        end
      end else if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else if (m_hold == MAX_HOLD) begin
        m_timeout        = 1;
        m_mask[m_owner]  = 1;
        m_ptr            = (m_owner + 1) % 4;
        m_owner          = -1;
      end else begin
        m_hold++;
      end
      for (int n = 0; n < 4; n++) if (!r[n]) m_mask[n] = 0;
    end
  end

  // Per-cycle comparison against the model plus structural invariants.
  always @(negedge clk) begin
    logic [3:0] e_gnt;
    if (rst_n) begin
      e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      check("model_gnt",       32'(gnt),       32'(e_gnt));
      check("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      check("model_gnt_id",    32'(gnt_id),    32'(m_last_id));
      check("model_timeout",   32'(timeout),   32'(m_timeout));
      check("inv_onehot",      32'($countones(gnt) <= 1), 32'(1));
      if (gnt_valid) check("inv_decode", 32'(gnt), 32'(4'b0001 << gnt_id));
      else           check("inv_zero",   32'(gnt), 32'(0));
      check("inv_timeout_excl", 32'(timeout & gnt_valid), 32'(0));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Leaves the caller at the first negedge where gnt_valid is seen.
  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (!gnt_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!gnt_valid) check({name, "_wait_grant_expired"}, 32'(gnt_valid), 32'(1));
  endtask

  task automatic count_hold(input logic [3:0] who, output int cnt);
    cnt = 0;
    while (gnt == who && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] exp_g [5];
    int cnt;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    rst_n = 1'b0;
    req   = 4'b0000;

    // Scenario 1: reset values, idle with no requests, asynchronous reset mid-grant.
    #12;
    check("rst_gnt",       32'(gnt),       32'(0));
    check("rst_gnt_id",    32'(gnt_id),    32'(0));
    check("rst_gnt_valid", 32'(gnt_valid), 32'(0));
    check("rst_timeout",   32'(timeout),   32'(0));
    do_reset();
    repeat (5) @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'(0));
    req = 4'b0100;
    wait_grant("s1");
    check("s1_gnt", 32'(gnt), 32'(4'b0100));
    #2 rst_n = 1'b0;
    #1 check("async_rst_gnt", 32'(gnt), 32'(0));
    check("async_rst_valid", 32'(gnt_valid), 32'(0));

    // Scenario 2: all request, each owner releases after 3 cycles; rotation with one idle gap.
    do_reset();
    req = 4'b1111;
    wait_grant("s2");
    for (int i = 0; i < 5; i++) begin
      check("s2_order_gnt", 32'(gnt),    32'(exp_g[i]));
      check("s2_order_id",  32'(gnt_id), 32'(i % 4));
      repeat (2) @(negedge clk);
      req = 4'b1111 & ~gnt;
      @(negedge clk);
      check("s2_gap", 32'(gnt_valid), 32'(0));
      req = 4'b1111;
      @(negedge clk);
    end

    // Scenario 3: lone requester 2, then 3 and 0 together resolved by pointer.
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    check("s3_lat_gnt", 32'(gnt),    32'(4'b0100));
    check("s3_lat_id",  32'(gnt_id), 32'(2));
    req = 4'b0000;
    @(negedge clk);
    req = 4'b1001;
    @(negedge clk);
    check("s3_ptr3_gnt", 32'(gnt),    32'(4'b1000));
    check("s3_ptr3_id",  32'(gnt_id), 32'(3));
    req = 4'b0001;
    repeat (2) @(negedge clk);
    check("s3_wrap_gnt", 32'(gnt), 32'(4'b0001));
    req = 4'b0000;
    @(negedge clk);

    // Scenario 4: requester 1 holds forever -> revoked after MAX_HOLD, no regrant until it drops.
    do_reset();
    req = 4'b0010;
    wait_grant("s4");
    count_hold(4'b0010, cnt);
    check("s4_hold_cycles", 32'(cnt),     32'(MAX_HOLD));
    check("s4_timeout",     32'(timeout), 32'(1));
    repeat (4) @(negedge clk);
    check("s4_masked", 32'(gnt_valid), 32'(0));
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0010;
    wait_grant("s4b");
    check("s4_regrant", 32'(gnt), 32'(4'b0010));
    req = 4'b0000;
    @(negedge clk);

    // Scenario 5: revocation of 1 hands the resource to 3 while 1 stays masked.
    do_reset();
    req = 4'b1010;
    wait_grant("s5");
    check("s5_first", 32'(gnt), 32'(4'b0010));
    count_hold(4'b0010, cnt);
    check("s5_hold_cycles", 32'(cnt),     32'(MAX_HOLD));
    check("s5_timeout",     32'(timeout), 32'(1));
    @(negedge clk);
    check("s5_next_gnt", 32'(gnt),    32'(4'b1000));
    check("s5_next_id",  32'(gnt_id), 32'(3));
    req = 4'b0010;
    repeat (3) @(negedge clk);
    check("s5_still_masked", 32'(gnt_valid), 32'(0));
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0010;
    wait_grant("s5b");
    check("s5_unmasked", 32'(gnt), 32'(4'b0010));
    req = 4'b0000;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter for one shared resource.
- Grants are one-hot: a 2-bit winner index, expanded with the same encoding as decoder_2to4 (index n drives bit n).
- Owners are rotated fairly, and a hold timeout stops any single requester from monopolising the resource.
- Sits between the requesting units and the shared resource's select lines.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one requester may hold the grant. Legal range 2..255.
- CNT_W, 8: hold-counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request bits. req[n] is high while requester n wants or holds the resource.
- gnt  output  4  one-hot grant. All zero when no owner.
- gnt_id  output  2  index of current owner. Valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is asserted
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0. Internal state: state=IDLE, ptr=0, hold_cnt=0, mask=4'b0000.
- Reset asserted mid-grant clears everything immediately (asynchronously). No completion of the current grant.
- States: IDLE and GRANT.
- IDLE, arbitration:
  - Eligible set is elig = req & ~mask.
  - If elig is nonzero, the winner is the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: gnt_id=winner, gnt=1<<winner, gnt_valid=1, hold_cnt=1, state=GRANT.
  - Latency: req sampled high in IDLE gives gnt high 1 cycle later.
  - If elig=0, stay in IDLE with outputs zero.
- GRANT, normal release:
  - When req[gnt_id]=0 on an edge: gnt=0, gnt_valid=0, ptr=gnt_id+1 (mod 4, wraps 3->0), state=IDLE.
  - gnt_id holds its last value while gnt_valid=0.
  - The release cycle is always followed by one IDLE cycle (one idle gap) before any new grant.
- GRANT, hold: while req[gnt_id]=1 and hold_cnt<MAX_HOLD, keep gnt and increment hold_cnt.
- GRANT, timeout:
  - Condition: req[gnt_id]=1 and hold_cnt==MAX_HOLD, i.e. gnt has been high MAX_HOLD cycles.
  - On that edge: gnt=0, gnt_valid=0, timeout=1 for exactly that one cycle, mask[gnt_id]=1, ptr=gnt_id+1, state=IDLE.
- Mask:
  - mask[n] clears on any edge where req[n]=0.
  - While mask[n]=1, requester n is not eligible. A revoked requester must drop req for at least one cycle before re-arbitrating.
  - Mask clearing is independent of state.
- Other requests during GRANT have no effect until the return to IDLE. There is no preemption.
- Simultaneous requests in the same cycle are resolved purely by ptr order.
- Invariants, at every edge:
  - gnt==0 whenever gnt_valid=0.
  - gnt==(1<<gnt_id) whenever gnt_valid=1.
  - popcount(gnt)<=1.
  - timeout=1 implies gnt_valid=0.
- req may change arbitrarily. Glitch-free inputs are assumed synchronous to clk. Synchronisation is the requester's responsibility.

Test Plan:
1. Reset, then req=4'b0000 for 5 cycles -> gnt=0000, gnt_valid=0, timeout=0 throughout. Assert rst_n=0 while gnt=0100 -> gnt=0000 immediately, without waiting for an edge.
2. After reset, req=4'b1111 held; each owner drops its req bit 3 cycles after grant and reasserts it 1 cycle later -> grant order 0001, 0010, 0100, 1000, 0001 (wrap), gnt_id 0,1,2,3,0, with one idle cycle between grants.
3. req=4'b0100 alone from reset -> gnt=0100, gnt_id=2 one cycle later. Drop req[2], then raise req=4'b1001 -> winner is 3 (ptr=3), then 0 after 3 releases.
4. With MAX_HOLD=16, req[1] held high permanently, others 0 -> gnt=0010 for exactly 16 cycles, then gnt=0000 with timeout=1 for 1 cycle. No regrant while req[1] stays high. Drop req[1] for 1 cycle and reassert -> granted again.
5. Same as 4 but req[3] also high -> after the timeout on 1, one IDLE cycle, then gnt=1000. Requester 1 stays masked until it deasserts.
6. Every cycle of scenarios 2–5: check the invariants (one-hot or zero gnt, gnt matches gnt_id per decoder encoding, timeout only with gnt_valid=0).
